// File: rtl/serial_sub_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial subtractor sequencer.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow_out, zero, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow_out, zero, busy
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A-B sequencer: one subtract cell with a registered borrow, LSB first.
// Latency: WIDTH edges from accept to out_valid; backpressure holds the result in DONE.
// Backpressure: in_ready only in IDLE; a result waits in DONE until out_ready.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_sub_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] diff_r;
    logic             bin;
    logic             borrow_r;
    logic             zero_r;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bout;
    logic             last;

    // Full-subtract cell built from two half-subtractors
    assign d       = a_sr[0] ^ b_sr[0] ^ bin;
    assign bout    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bin);
    assign res_nxt = WIDTH'({d, res_sr} >> 1);
    assign last    = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = SHIFT;
            SHIFT:   if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            diff_r   <= '0;
            bin      <= 1'b0;
            borrow_r <= 1'b0;
            zero_r   <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        res_sr <= '0;
                        bin    <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    bin    <= bout;
                    // Counter parks at WIDTH-1; the result registers load only here
                    if (last) begin
                        diff_r   <= res_nxt;
                        borrow_r <= bout;
                        zero_r   <= (res_nxt == '0);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.busy       = (state == SHIFT);
    assign bus.diff       = diff_r;
    assign bus.borrow_out = borrow_r;
    assign bus.zero       = zero_r;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random checks of serial_sub_ctrl at WIDTH 1, 8 and 16 against arithmetic expectations.
module tb_serial_sub_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   last_acc [0:16];

    serial_sub_ctrl_if #(.WIDTH(1))  i1 ();
    serial_sub_ctrl_if #(.WIDTH(8))  i8 ();
    serial_sub_ctrl_if #(.WIDTH(16)) i16 ();

    serial_sub_ctrl #(.WIDTH(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(i1));
    serial_sub_ctrl #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8));
    serial_sub_ctrl #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        case (w)
            1:       return i1.in_ready;
            16:      return i16.in_ready;
            default: return i8.in_ready;
        endcase
    endfunction

    function automatic logic ov(input int w);
        case (w)
            1:       return i1.out_valid;
            16:      return i16.out_valid;
            default: return i8.out_valid;
        endcase
    endfunction

    function automatic logic bsy(input int w);
        case (w)
            1:       return i1.busy;
            16:      return i16.busy;
            default: return i8.busy;
        endcase
    endfunction

    function automatic logic bor(input int w);
        case (w)
            1:       return i1.borrow_out;
            16:      return i16.borrow_out;
            default: return i8.borrow_out;
        endcase
    endfunction

    function automatic logic zr(input int w);
        case (w)
            1:       return i1.zero;
            16:      return i16.zero;
            default: return i8.zero;
        endcase
    endfunction

    function automatic logic [63:0] dif(input int w);
        case (w)
            1:       return 64'(i1.diff);
            16:      return 64'(i16.diff);
            default: return 64'(i8.diff);
        endcase
    endfunction

    task automatic drive(input int w, input logic v, input logic [63:0] av, input logic [63:0] bv);
        case (w)
            1:       begin i1.in_valid = v;  i1.a = av[0:0];   i1.b = bv[0:0];   end
            16:      begin i16.in_valid = v; i16.a = av[15:0]; i16.b = bv[15:0]; end
            default: begin i8.in_valid = v;  i8.a = av[7:0];   i8.b = bv[7:0];   end
        endcase
    endtask

    task automatic set_ordy(input int w, input logic r);
        case (w)
            1:       i1.out_ready = r;
            16:      i16.out_ready = r;
            default: i8.out_ready = r;
        endcase
    endtask

    // One operation: accept, latency, result, optional backpressure for 'hold' cycles, handshake
    task automatic do_op(input int w, input logic [63:0] av_in, input logic [63:0] bv_in,
                         input bit keep_valid, input int hold);
        logic [63:0] m;
        logic [63:0] av;
        logic [63:0] bv;
        logic [63:0] ed;
        logic        eb;
        int          n;
        int          t_acc;
        m  = (64'd1 << w) - 64'd1;
        av = av_in & m;
        bv = bv_in & m;
        ed = (av - bv) & m;
        eb = (av < bv);
        set_ordy(w, hold == 0);
        n = 0;
        while (rdy(w) !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_wait", 64'(rdy(w)), 64'd1);
        drive(w, 1'b1, av, bv);
        @(posedge clk); #1;
        t_acc = cyc;
        if (last_acc[w] >= 0) check("op_period_ge_w2", 64'(t_acc - last_acc[w] >= w + 2), 64'd1);
        last_acc[w] = t_acc;
        check("busy_after_accept", 64'(bsy(w)), 64'd1);
        check("in_ready_in_shift", 64'(rdy(w)), 64'd0);
        drive(w, keep_valid, 64'($urandom), 64'($urandom));
        n = 0;
        while (ov(w) !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("latency", 64'(n), 64'(w));
        check("diff", dif(w), ed);
        check("borrow_out", 64'(bor(w)), 64'(eb));
        check("zero", 64'(zr(w)), 64'(ed == 64'd0));
        check("busy_in_done", 64'(bsy(w)), 64'd0);
        for (int k = 0; k < hold; k++) begin
            drive(w, 1'($urandom), 64'($urandom), 64'($urandom));
            @(posedge clk); #1;
            check("bp_out_valid", 64'(ov(w)), 64'd1);
            check("bp_in_ready", 64'(rdy(w)), 64'd0);
            check("bp_diff", dif(w), ed);
            check("bp_borrow", 64'(bor(w)), 64'(eb));
        end
        drive(w, keep_valid, 64'($urandom), 64'($urandom));
        set_ordy(w, 1'b1);
        @(posedge clk); #1;
        check("out_valid_drop", 64'(ov(w)), 64'd0);
        check("idle_in_ready", 64'(rdy(w)), 64'd1);
        check("diff_retained", dif(w), ed);
        set_ordy(w, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        for (int i = 0; i <= 16; i++) last_acc[i] = -1;
        rst_n = 1'b0;
        drive(1, 1'b0, 64'd0, 64'd0);
        drive(8, 1'b0, 64'd0, 64'd0);
        drive(16, 1'b0, 64'd0, 64'd0);
        set_ordy(1, 1'b0);
        set_ordy(8, 1'b0);
        set_ordy(16, 1'b0);
        #3;
        check("rst_in_ready", 64'(rdy(8)), 64'd1);
        check("rst_out_valid", 64'(ov(8)), 64'd0);
        check("rst_busy", 64'(bsy(8)), 64'd0);
        check("rst_diff", dif(8), 64'd0);
        check("rst_borrow", 64'(bor(8)), 64'd0);
        check("rst_zero", 64'(zr(8)), 64'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(8, 64'h05, 64'h03, 1'b0, 0);
        do_op(8, 64'h03, 64'h05, 1'b0, 0);
        do_op(8, 64'h00, 64'hFF, 1'b0, 0);
        do_op(8, 64'hA5, 64'hA5, 1'b0, 0);
        do_op(8, 64'h31, 64'h9C, 1'b0, 5);

        // Asynchronous reset mid-clock while the bit counter is at 3
        drive(8, 1'b1, 64'h55, 64'h22);
        @(posedge clk); #1;
        drive(8, 1'b0, 64'h00, 64'h00);
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_busy", 64'(bsy(8)), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(bsy(8)), 64'd0);
        check("mid_rst_in_ready", 64'(rdy(8)), 64'd1);
        check("mid_rst_out_valid", 64'(ov(8)), 64'd0);
        check("mid_rst_diff", dif(8), 64'd0);
        check("mid_rst_borrow", 64'(bor(8)), 64'd0);
        check("mid_rst_zero", 64'(zr(8)), 64'd0);
        #4;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("post_rst_no_result", 64'(ov(8)), 64'd0);
        end
        do_op(8, 64'h10, 64'h01, 1'b0, 0);

        for (int i = 0; i < 20; i++) do_op(8, 64'($urandom), 64'($urandom), 1'b1, int'($urandom_range(0, 3)));
        for (int i = 0; i < 4; i++)  do_op(1, 64'(i >> 1), 64'(i & 1), 1'b1, int'($urandom_range(0, 2)));
        for (int i = 0; i < 20; i++) do_op(16, 64'($urandom), 64'($urandom), 1'b1, int'($urandom_range(0, 3)));
        do_op(16, 64'h1234, 64'h1234, 1'b1, 0);
        do_op(16, 64'h0000, 64'hFFFF, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
